memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameters: none; word_t = 32 bits, regbits_t = 5 bits from cpu_types_pkg.
REQ-002 CLK  in  1  single clock, all state on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 ihit  in  1  instruction-side hit; pipeline advance enable.
REQ-005 dhit  in  1  data-cache access complete this cycle.
REQ-006 flush  in  1  load bubble instead of EX inputs on next advance.
REQ-007 out  in  32  EX ALU result / effective address.
REQ-008 read_dat2_next  in  32  EX store data.
REQ-009 addr_curr4, lower_zero_next  in  32 each  PC+4 and LUI value.
REQ-010 write_reg_next  in  5  destination register.
REQ-011 regWEN_next, mem_read_next, mem_write_next, memtoreg_next, jal_flag_next, lui_flag_next, halt_next  in  1 each  EX control.
REQ-012 dmemload  in  32  cache read data, valid when dhit.
REQ-013 dmemREN, dmemWEN  out  1 each  cache request strobes.
REQ-014 dmemaddr, dmemstore  out  32 each  cache address / write data.
REQ-015 mem_stall  out  1  MEM busy; upstream holds.
REQ-016 forward_mem  out  32  MEM-stage value for EX forwarding.
REQ-017 wb_wdat  out  32, wb_wsel  out  5, wb_WEN  out  1, wb_halt  out  1  MEM/WB latch to register file.

Function
REQ-018 Two latches: EX/MEM (all EX inputs) and MEM/WB (wb_* outputs); one 32-bit load-hold register.
REQ-019 FSM states IDLE, ACCESS, DONE.
REQ-020 adv = ihit AND state != ACCESS; all latch updates occur only on adv, except load-hold capture.
REQ-021 On adv: EX/MEM <- EX inputs, or all-zero bubble when flush=1.
REQ-022 On adv: next state = ACCESS if newly loaded entry has mem_read or mem_write set (not bubble), else IDLE.
REQ-023 ACCESS: dmemREN = EX/MEM mem_read AND NOT mem_write; dmemWEN = EX/MEM mem_write (write wins if both set).
REQ-024 dmemaddr = EX/MEM out, dmemstore = EX/MEM read_dat2, stable for entire ACCESS.
REQ-025 ACCESS with dhit: load-hold <- dmemload, next state DONE; without dhit: remain ACCESS.
REQ-026 dmemREN = dmemWEN = 0 in IDLE and DONE; dhit outside ACCESS ignored.
REQ-027 mem_stall = 1 iff state = ACCESS (including the dhit cycle: one-cycle DONE bubble is intended).
REQ-028 DONE without ihit: hold state, latches, load-hold.
REQ-029 Select value sel: jal -> addr_curr4; else lui -> lower_zero; else memtoreg -> load-hold; else out (from EX/MEM).
REQ-030 On adv: wb_wdat <- sel, wb_wsel <- write_reg, wb_WEN <- regWEN, all from EX/MEM.
REQ-031 forward_mem = sel combinationally from EX/MEM; for loads valid only in DONE (load-use stall upstream).
REQ-032 wb_halt sticky: set on adv when EX/MEM halt = 1, cleared only by reset; once set, wb_WEN forced 0 thereafter.
REQ-033 flush and mem_stall simultaneous: flush takes effect on the next adv, not before.

Reset
REQ-034 nRST low: state IDLE, EX/MEM, MEM/WB, load-hold all zero immediately (async).
REQ-035 Reset outputs: dmemREN=dmemWEN=0, mem_stall=0, forward_mem=0, wb_wdat=0, wb_wsel=0, wb_WEN=0, wb_halt=0.
REQ-036 Reset during ACCESS: requests drop in same cycle; outstanding access abandoned.

Verification
REQ-037 ALU op out=0x0000_0010, wsel=5, regWEN=1, ihit two cycles -> wb_wdat=0x10, wb_wsel=5, wb_WEN=1; dmemREN/WEN never high.
REQ-038 Load addr=0x100, dhit after 3 cycles with dmemload=0xDEAD_BEEF -> dmemREN high 3 cycles, mem_stall high 3 cycles, next ihit gives wb_wdat=0xDEADBEEF.
REQ-039 Store addr=0x200 data=0x1234 -> dmemWEN=1, dmemaddr=0x200, dmemstore=0x1234 until dhit; wb_WEN=0 afterwards.
REQ-040 flush=1 with load on inputs, ihit -> no dmemREN, state IDLE, next wb_WEN=0.
REQ-041 jal with addr_curr4=0x44 -> forward_mem=0x44, then wb_wdat=0x44, wb_wsel=31.
REQ-042 nRST low mid-ACCESS -> dmemREN=0 same cycle; halt_next=1 then ihit -> wb_halt=1 persists with ihit toggling.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline MEM stage: EX/MEM latch, data-cache access FSM, MEM/WB latch
module memory_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush,
  input  logic [31:0] out,
  input  logic [31:0] read_dat2_next,
  input  logic [31:0] addr_curr4,
  input  logic [31:0] lower_zero_next,
  input  logic [4:0]  write_reg_next,
  input  logic        regWEN_next,
  input  logic        mem_read_next,
  input  logic        mem_write_next,
  input  logic        memtoreg_next,
  input  logic        jal_flag_next,
  input  logic        lui_flag_next,
  input  logic        halt_next,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] forward_mem,
  output logic [31:0] wb_wdat,
  output logic [4:0]  wb_wsel,
  output logic        wb_WEN,
  output logic        wb_halt
);

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    word_t    alu;
    word_t    rdat2;
    word_t    pc4;
    word_t    lui_val;
    regbits_t wsel;
    logic     regwen;
    logic     mread;
    logic     mwrite;
    logic     m2r;
    logic     jal;
    logic     lui;
    logic     halt;
  } exmem_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t   state_q, state_d;
  exmem_t   exmem_q, exmem_d;
  word_t    hold_q;
  word_t    wb_wdat_q;
  regbits_t wb_wsel_q;
  logic     wb_wen_q;
  logic     wb_halt_q;
  logic     adv;
  word_t    sel;

  // The whole stage advances with the fetch side unless a cache access is still in flight
  assign adv = ihit && (state_q != ACCESS);

  // Candidate EX/MEM contents: the EX bundle, or an all-zero bubble when flushing
  always_comb begin
    exmem_d = '0;
    if (!flush) begin
      exmem_d.alu     = out;
      exmem_d.rdat2   = read_dat2_next;
      exmem_d.pc4     = addr_curr4;
      exmem_d.lui_val = lower_zero_next;
      exmem_d.wsel    = write_reg_next;
      exmem_d.regwen  = regWEN_next;
      exmem_d.mread   = mem_read_next;
      exmem_d.mwrite  = mem_write_next;
      exmem_d.m2r     = memtoreg_next;
      exmem_d.jal     = jal_flag_next;
      exmem_d.lui     = lui_flag_next;
      exmem_d.halt    = halt_next;
    end
  end

  // Access FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and cache strobes; a store wins when both read and write are flagged
  always_comb begin
    state_d   = state_q;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (adv) state_d = (exmem_d.mread || exmem_d.mwrite) ? ACCESS : IDLE;
      end
      ACCESS: begin
        mem_stall = 1'b1;
        dmemREN   = exmem_q.mread && !exmem_q.mwrite;
        dmemWEN   = exmem_q.mwrite;
        if (dhit) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // EX/MEM latch, loaded only when the pipeline advances
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)    exmem_q <= '0;
    else if (adv) exmem_q <= exmem_d;
  end

  // Load-hold captures cache data on the completing cycle of an access
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          hold_q <= '0;
    else if (state_q == ACCESS && dhit) hold_q <= dmemload;
  end

  // Result select shared by forwarding and write-back
  always_comb begin
    sel = exmem_q.alu;
    if (exmem_q.jal)      sel = exmem_q.pc4;
    else if (exmem_q.lui) sel = exmem_q.lui_val;
    else if (exmem_q.m2r) sel = hold_q;
  end

  // MEM/WB latch; halt is sticky until reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_wdat_q <= '0;
      wb_wsel_q <= '0;
      wb_wen_q  <= 1'b0;
      wb_halt_q <= 1'b0;
    end else if (adv) begin
      wb_wdat_q <= sel;
      wb_wsel_q <= exmem_q.wsel;
      wb_wen_q  <= exmem_q.regwen;
      if (exmem_q.halt) wb_halt_q <= 1'b1;
    end
  end

  assign dmemaddr    = exmem_q.alu;
  assign dmemstore   = exmem_q.rdat2;
  assign forward_mem = sel;
  assign wb_wdat     = wb_wdat_q;
  assign wb_wsel     = wb_wsel_q;
  assign wb_WEN      = wb_wen_q && !wb_halt_q;
  assign wb_halt     = wb_halt_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] pc4;
    logic [31:0] luiv;
    logic [4:0]  wreg;
    logic        regwen;
    logic        rd;
    logic        wr;
    logic        m2r;
    logic        jal;
    logic        luif;
    logic        halt;
  } instr_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] dmemload = '0;
  instr_t      drv = '0;

  logic        dmemREN, dmemWEN, mem_stall, wb_WEN, wb_halt;
  logic [31:0] dmemaddr, dmemstore, forward_mem, wb_wdat;
  logic [4:0]  wb_wsel;

  int total = 0;
  int bad = 0;

  // behavioural model: current instruction in MEM, whether its access is outstanding, write-back view
  instr_t      m_ent;
  logic        m_busy;
  logic [31:0] m_hold, m_wdat;
  logic [4:0]  m_wsel;
  logic        m_wen, m_halt;

  always #5 CLK = ~CLK;

  memory_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .out(drv.alu), .read_dat2_next(drv.rd2), .addr_curr4(drv.pc4),
    .lower_zero_next(drv.luiv), .write_reg_next(drv.wreg),
    .regWEN_next(drv.regwen), .mem_read_next(drv.rd), .mem_write_next(drv.wr),
    .memtoreg_next(drv.m2r), .jal_flag_next(drv.jal), .lui_flag_next(drv.luif),
    .halt_next(drv.halt), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .forward_mem(forward_mem), .wb_wdat(wb_wdat),
    .wb_wsel(wb_wsel), .wb_WEN(wb_WEN), .wb_halt(wb_halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_sel();
    if (m_ent.jal)  return m_ent.pc4;
    if (m_ent.luif) return m_ent.luiv;
    if (m_ent.m2r)  return m_hold;
    return m_ent.alu;
  endfunction

  task automatic model_reset();
    m_ent = '0; m_busy = 0; m_hold = '0; m_wdat = '0; m_wsel = '0; m_wen = 0; m_halt = 0;
  endtask

  // one clock of the model, applied with the inputs currently driven
  task automatic model_step();
    if (!nRST) begin
      model_reset();
    end else if (ihit && !m_busy) begin
      m_wdat = model_sel();
      m_wsel = m_ent.wreg;
      m_wen  = m_ent.regwen;
      if (m_ent.halt) m_halt = 1;
      m_ent  = flush ? '0 : drv;
      m_busy = m_ent.rd || m_ent.wr;
    end else if (m_busy && dhit) begin
      m_hold = dmemload;
      m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    check("dmemREN", dmemREN, m_busy && m_ent.rd && !m_ent.wr);
    check("dmemWEN", dmemWEN, m_busy && m_ent.wr);
    check("mem_stall", mem_stall, m_busy);
    if (m_busy) begin
      check("dmemaddr", dmemaddr, m_ent.alu);
      check("dmemstore", dmemstore, m_ent.rd2);
    end
    check("forward_mem", forward_mem, model_sel());
    check("wb_wdat", wb_wdat, m_wdat);
    check("wb_wsel", wb_wsel, m_wsel);
    check("wb_WEN", wb_WEN, m_wen && !m_halt);
    check("wb_halt", wb_halt, m_halt);
  endtask

  // compare at the falling edge, advance the model, then return 1ns after the rising edge
  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  instr_t nop, t;
  int n_ren, n_stall;

  initial begin
    model_reset();
    nop = '0;
    cycle();
    cycle();
    check("rst_wb_wdat", wb_wdat, 32'h0);
    check("rst_fwd", forward_mem, 32'h0);
    check("rst_stall", mem_stall, 1'b0);
    nRST = 1'b1;

    // ALU op through to write-back
    t = '0; t.alu = 32'h10; t.wreg = 5'd5; t.regwen = 1;
    drv = t; ihit = 1;
    cycle();
    drv = nop;
    cycle();
    check("alu_wdat", wb_wdat, 32'h10);
    check("alu_wsel", wb_wsel, 32'd5);
    check("alu_wen", wb_WEN, 1'b1);

    // load with dhit on the third access cycle
    t = '0; t.alu = 32'h100; t.rd = 1; t.m2r = 1; t.regwen = 1; t.wreg = 5'd3;
    drv = t; dhit = 0;
    cycle();
    drv = nop; n_ren = 0; n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 2);
      dmemload = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
      n_ren += int'(dmemREN);
      n_stall += int'(mem_stall);
      cycle();
    end
    dhit = 0;
    check("load_ren_cycles", n_ren, 3);
    check("load_stall_cycles", n_stall, 3);
    check("load_wdat", wb_wdat, 32'hDEAD_BEEF);

    // store held until dhit
    t = '0; t.alu = 32'h200; t.rd2 = 32'h1234; t.wr = 1;
    drv = t;
    cycle();
    drv = nop;
    check("st_wen", dmemWEN, 1'b1);
    check("st_addr", dmemaddr, 32'h200);
    check("st_data", dmemstore, 32'h1234);
    cycle();
    check("st_wen_hold", dmemWEN, 1'b1);
    dhit = 1;
    cycle();
    dhit = 0;
    cycle();
    check("st_wb_wen", wb_WEN, 1'b0);

    // flushed load becomes a bubble
    t = '0; t.alu = 32'h300; t.rd = 1; t.m2r = 1; t.regwen = 1; t.wreg = 5'd7;
    drv = t; flush = 1;
    cycle();
    flush = 0;
    check("flush_ren", dmemREN, 1'b0);
    check("flush_stall", mem_stall, 1'b0);
    drv = nop;
    cycle();
    check("flush_wb_wen", wb_WEN, 1'b0);

    // jal forwards and writes PC+4 to r31
    t = '0; t.pc4 = 32'h44; t.jal = 1; t.regwen = 1; t.wreg = 5'd31;
    drv = t;
    cycle();
    check("jal_fwd", forward_mem, 32'h44);
    drv = nop;
    cycle();
    check("jal_wdat", wb_wdat, 32'h44);
    check("jal_wsel", wb_wsel, 32'd31);

    // randomized traffic, no halts
    for (int i = 0; i < 400; i++) begin
      t.alu    = $urandom;
      t.rd2    = $urandom;
      t.pc4    = $urandom;
      t.luiv   = $urandom;
      t.wreg   = 5'($urandom);
      t.regwen = 1'($urandom);
      t.rd     = ($urandom_range(0, 2) == 0);
      t.wr     = ($urandom_range(0, 3) == 0);
      t.m2r    = 1'($urandom);
      t.jal    = ($urandom_range(0, 5) == 0);
      t.luif   = ($urandom_range(0, 5) == 0);
      t.halt   = 0;
      drv      = t;
      ihit     = ($urandom_range(0, 9) < 7);
      dhit     = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 9) < 2);
      dmemload = $urandom;
      cycle();
    end
    ihit = 1; dhit = 0; flush = 0; drv = nop;
    cycle();

    // reset in the middle of an access
    t = '0; t.alu = 32'h400; t.rd = 1; t.m2r = 1;
    drv = t;
    cycle();
    drv = nop;
    check("pre_rst_ren", dmemREN, 1'b1);
    nRST = 0;
    #1;
    check("async_rst_ren", dmemREN, 1'b0);
    check("async_rst_stall", mem_stall, 1'b0);
    model_reset();
    cycle();
    nRST = 1;

    // halt becomes sticky and masks later writes
    t = '0; t.halt = 1;
    drv = t;
    cycle();
    drv = nop;
    cycle();
    check("halt_set", wb_halt, 1'b1);
    for (int i = 0; i < 8; i++) begin
      t = '0; t.alu = $urandom; t.regwen = 1; t.wreg = 5'($urandom);
      drv = t;
      ihit = i[0];
      cycle();
      check("halt_sticky", wb_halt, 1'b1);
      check("halt_no_wen", wb_WEN, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
